// File: rtl/pulse_burst_tx.sv
// Burst pulse transmitter: emits count_in single-cycle strobes separated by gap_in idle cycles.
// Optional feature macro: PULSE_BURST_TX_ABORT_EN adds an `abort` input that cuts a burst short.
module pulse_burst_tx #(
    parameter int CNT_W = 3,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count_in,
    input  logic [GAP_W-1:0] gap_in,
`ifdef PULSE_BURST_TX_ABORT_EN
    input  logic             abort,
`endif
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_reg;
    logic [GAP_W-1:0] gap_cnt;
    logic             abort_req;

`ifdef PULSE_BURST_TX_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Outputs are set from the state being entered, so they line up with that state's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            gap_reg   <= '0;
            gap_cnt   <= '0;
        end else begin
            pulse <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= count_in;
                        gap_reg   <= gap_in;
                        busy      <= 1'b1;
                        if (count_in != '0) begin
                            state <= PULSE;
                            pulse <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (remaining != '0)
                        remaining <= remaining - CNT_W'(1);
                    if (abort_req) begin
                        remaining <= '0;
                        state     <= DONE;
                        done      <= 1'b1;
                    end else if (remaining <= CNT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (gap_reg == '0) begin
                        pulse <= 1'b1;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= gap_reg;
                    end
                end
                GAP: begin
                    if (abort_req) begin
                        remaining <= '0;
                        gap_cnt   <= '0;
                        state     <= DONE;
                        done      <= 1'b1;
                    end else if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        state   <= PULSE;
                        pulse   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_burst_tx.sv
// Self-checking bench for pulse_burst_tx: per-cycle expected outputs are generated from the
// burst description, queued at start, and compared against the DUT each cycle.
module tb_pulse_burst_tx;
    localparam int CNT_W = 3;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] count_in = '0;
    logic [GAP_W-1:0] gap_in = '0;
    logic             pulse, busy, done;
    logic [CNT_W-1:0] remaining;
`ifdef PULSE_BURST_TX_ABORT_EN
    logic             abort = 1'b0;
`endif

    pulse_burst_tx #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count_in(count_in), .gap_in(gap_in),
`ifdef PULSE_BURST_TX_ABORT_EN
        .abort(abort),
`endif
        .pulse(pulse), .busy(busy), .done(done), .remaining(remaining)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             p;
        logic             b;
        logic             d;
        logic [CNT_W-1:0] r;
    } obs_t;

    typedef struct {
        int c;
        int g;
        int exp_pulses;
        int exp_busy;
    } vec_t;

    obs_t exp_q[$];
    vec_t vecs[6];
    int   errs = 0;
    int   checks = 0;
    int   npulse, nbusy;

    // Downstream 3-bit event counter fed by pulse
    logic [2:0] ev_cnt;
    logic       cnt_clr = 1'b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ev_cnt <= '0;
        else if (cnt_clr) ev_cnt <= '0;
        else if (pulse)   ev_cnt <= ev_cnt + 3'd1;
    end

    function automatic obs_t cur();
        obs_t o;
        o.p = pulse; o.b = busy; o.d = done; o.r = remaining;
        return o;
    endfunction

    function automatic obs_t mk(logic p, logic b, logic d, int r);
        obs_t o;
        o.p = p; o.b = b; o.d = d; o.r = CNT_W'(r);
        return o;
    endfunction

    task automatic chk(string nm, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got p=%b b=%b d=%b rem=%0d, want p=%b b=%b d=%b rem=%0d",
                     nm, act.p, act.b, act.d, act.r, exp.p, exp.b, exp.d, exp.r);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Expected trace: pulse with remaining=c-i, gap cycles owing one fewer, then done.
    function automatic void push_burst(int c, int g);
        for (int i = 0; i < c; i++) begin
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, c - i));
            if (i < c - 1)
                for (int k = 0; k < g; k++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, c - i - 1));
        end
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 0));
    endfunction

    task automatic drain_n(int n, string nm);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            e = exp_q.pop_front();
            chk(nm, cur(), e);
            npulse += int'(pulse);
            nbusy  += int'(busy);
        end
    endtask

    task automatic drain_all(string nm);
        npulse = 0;
        nbusy  = 0;
        drain_n(exp_q.size(), nm);
    endtask

    // Called at a negedge; leaves the bench at a negedge with the DUT idle.
    task automatic run_burst(int c, int g, string nm);
        start = 1'b1; count_in = CNT_W'(c); gap_in = GAP_W'(g);
        push_burst(c, g);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
        @(posedge clk);
        #1;
        start = 1'b0;
        count_in = CNT_W'($urandom);
        gap_in = GAP_W'($urandom);
        drain_all(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{c: 3, g: 2,  exp_pulses: 3, exp_busy: 8};
        vecs[1] = '{c: 3, g: 0,  exp_pulses: 3, exp_busy: 4};
        vecs[2] = '{c: 0, g: 5,  exp_pulses: 0, exp_busy: 1};
        vecs[3] = '{c: 1, g: 15, exp_pulses: 1, exp_busy: 2};
        vecs[4] = '{c: 2, g: 1,  exp_pulses: 2, exp_busy: 4};
        vecs[5] = '{c: 4, g: 3,  exp_pulses: 4, exp_busy: 14};

        // Reset held, then idle with start low
        repeat (2) begin
            @(negedge clk);
            chk("in_reset", cur(), mk(1'b0, 1'b0, 1'b0, 0));
        end
        rst_n = 1'b1;
        repeat (10) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
        drain_all("idle");

        foreach (vecs[i]) begin
            run_burst(vecs[i].c, vecs[i].g, $sformatf("vec%0d", i));
            chk_int($sformatf("vec%0d_pulses", i), npulse, vecs[i].exp_pulses);
            chk_int($sformatf("vec%0d_busy", i), nbusy, vecs[i].exp_busy);
        end

        // Full scale with start held high: second burst accepted only in the idle cycle after done
        start = 1'b1; count_in = 3'd7; gap_in = 4'd15;
        push_burst(7, 15);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
        push_burst(2, 0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
        @(posedge clk);
        #1;
        count_in = 3'd2; gap_in = 4'd0;
        npulse = 0; nbusy = 0;
        drain_n(99, "full_scale");
        chk_int("full_scale_pulses", npulse, 7);
        chk_int("full_scale_busy", nbusy, 98);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain_all("restart_after_hold");
        chk_int("restart_pulses", npulse, 2);

        // Asynchronous reset during the second GAP cycle of a 5-pulse burst
        start = 1'b1; count_in = 3'd5; gap_in = 4'd1;
        push_burst(5, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain_n(3, "pre_reset");
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", cur(), mk(1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        chk("rst_hold", cur(), mk(1'b0, 1'b0, 1'b0, 0));
        rst_n = 1'b1;
        repeat (3) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
        drain_all("post_reset_idle");
        run_burst(5, 1, "post_reset_burst");
        chk_int("post_reset_pulses", npulse, 5);

        // Downstream event counter accumulates 1, 4, 7 pulses mod 8
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        run_burst(1, 0, "ev1");
        chk_int("ev_cnt_after_1", int'(ev_cnt), 1);
        run_burst(4, 2, "ev4");
        chk_int("ev_cnt_after_4", int'(ev_cnt), 5);
        run_burst(7, 1, "ev7");
        chk_int("ev_cnt_after_7", int'(ev_cnt), 4);

`ifdef PULSE_BURST_TX_ABORT_EN
        // Abort in a GAP cycle: next cycle is done with nothing owed
        start = 1'b1; count_in = 3'd4; gap_in = 4'd2;
        push_burst(4, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain_n(2, "pre_abort");
        exp_q.delete();
        abort = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
        @(posedge clk);
        #1;
        abort = 1'b0;
        drain_all("abort");
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
